// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch prediction/resolution controller.
// Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
package branch_pkg;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_STRONG_NT = 2'b00;
    localparam bht_ctr_t BHT_WEAK_NT   = 2'b01;
    localparam bht_ctr_t BHT_STRONG_T  = 2'b11;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bctrl_state_t;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != BHT_STRONG_T) res = ctr + 2'd1;
        end else begin
            if (ctr != BHT_STRONG_NT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_ctrl_bht_table.sv
// Bimodal counter table: one combinational read port, one read-modify-write
// update port, with write-first bypass when both address the same entry.
module bht_table
    import branch_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IW      = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_pred,
    input  logic          upd_en,
    input  logic [IW-1:0] upd_idx,
    input  logic          upd_taken
);

    bht_ctr_t ctr_reg [ENTRIES];
    bht_ctr_t upd_next;

    assign upd_next = bht_next(ctr_reg[upd_idx], upd_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_reg[i] <= BHT_WEAK_NT;
            end
        end else if (upd_en) begin
            ctr_reg[upd_idx] <= upd_next;
        end
    end

    // Decode sees the value being written this cycle, not the stale one.
    always_comb begin
        rd_pred = ctr_reg[rd_idx][1];
        if (upd_en && (upd_idx == rd_idx)) begin
            rd_pred = upd_next[1];
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch predictor and resolver: bimodal prediction in Decode, training and
// one-cycle redirect/flush on mispredict in Execute. Optional performance
// counters are built when BRANCH_CTRL_PERF_EN is defined.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branchD,
    input  logic [XLEN-1:0] PCD,
    output logic            predTakenD,
    input  logic            branchE,
    input  logic            stallE,
    input  logic [XLEN-1:0] PCE,
    input  logic            predTakenE,
    input  logic            branchTakenE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] PCPlus4E,
    output logic            redirectF,
    output logic [XLEN-1:0] redirectPCF,
    output logic            flushD,
    output logic            flushE,
    output logic [31:0]     branchCount,
    output logic [31:0]     mispredCount
);

    localparam int IW = $clog2(BHT_ENTRIES);

    bctrl_state_t    state_reg, state_next;
    logic [XLEN-1:0] redirect_pc_reg;
    logic            resolve;
    logic            mispred;
    logic            table_pred;

    // Only the word-index bits of the PCs address the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCD[XLEN-1:IW+2], PCD[1:0], PCE[XLEN-1:IW+2], PCE[1:0]};

    assign resolve = branchE & ~stallE & (state_reg == RUN);
    assign mispred = predTakenE != branchTakenE;

    bht_table #(
        .ENTRIES (BHT_ENTRIES),
        .IW      (IW)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (PCD[IW+1:2]),
        .rd_pred   (table_pred),
        .upd_en    (resolve),
        .upd_idx   (PCE[IW+1:2]),
        .upd_taken (branchTakenE)
    );

    assign predTakenD = branchD & table_pred;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (resolve && mispred) state_next = FLUSH;
            FLUSH:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            redirect_pc_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (resolve && mispred) begin
                redirect_pc_reg <= branchTakenE ? PCTargetE : PCPlus4E;
            end
        end
    end

    // The FLUSH state itself is the registered redirect pulse.
    assign redirectF   = (state_reg == FLUSH);
    assign flushD      = (state_reg == FLUSH);
    assign flushE      = (state_reg == FLUSH);
    assign redirectPCF = redirect_pc_reg;

`ifdef BRANCH_CTRL_PERF_EN
    logic [31:0] branch_count_reg;
    logic [31:0] mispred_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_reg  <= '0;
            mispred_count_reg <= '0;
        end else if (resolve) begin
            branch_count_reg <= branch_count_reg + 32'd1;
            if (mispred) begin
                mispred_count_reg <= mispred_count_reg + 32'd1;
            end
        end
    end

    assign branchCount  = branch_count_reg;
    assign mispredCount = mispred_count_reg;
`else
    assign branchCount  = '0;
    assign mispredCount = '0;
`endif

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch prediction and resolution controller for the five-stage pipeline. It gives a direction prediction in Decode from a bimodal 2-bit counter table. In Execute it compares the prediction with the branch unit's `branchTakenE`, trains the table, and on a mispredict drives a registered one-cycle redirect and flush sequence to the fetch PC mux and the hazard unit.

## Interface
Parameters:
- `BHT_ENTRIES`, 64: counter table depth; power of two, ≥4.
- `XLEN`, 32: PC width.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `branchD`  in  1  Decode holds a conditional branch.
- `PCD`  in  XLEN  Decode PC.
- `predTakenD`  out  1  combinational prediction for `PCD`; 0 when `branchD`=0.
- `branchE`  in  1  Execute holds a valid conditional branch.
- `stallE`  in  1  Execute stalled; no resolution this cycle.
- `PCE`  in  XLEN  Execute PC.
- `predTakenE`  in  1  `predTakenD` carried down the pipeline.
- `branchTakenE`  in  1  branch unit outcome.
- `PCTargetE`, `PCPlus4E`  in  XLEN  taken and fall-through addresses.
- `redirectF`  out  1  fetch must load `redirectPCF`.
- `redirectPCF`  out  XLEN  corrected PC.
- `flushD`, `flushE`  out  1  kill wrong-path Decode and Execute instructions.
- `branchCount`, `mispredCount`  out  32  performance counters (see Configuration).

## Operation
- Table index = `PC[$clog2(BHT_ENTRIES)+1:2]`. Entry encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = entry[1].
- Resolve event = `branchE & ~stallE & state==RUN`.
- On a resolve event:
  - Entry at `PCE` increments if taken, decrements if not. It saturates at 11 and 00.
  - Mispredict = `predTakenE != branchTakenE`.
- FSM:
  - RUN: on a resolve event with a mispredict, register `redirectPCF` (`branchTakenE ? PCTargetE : PCPlus4E`) and go to FLUSH. Otherwise stay in RUN.
  - FLUSH: `redirectF`=`flushD`=`flushE`=1 for exactly one cycle, then return to RUN unconditionally. Resolve events are ignored in FLUSH, because the Execute instruction is on the wrong path. The table is not updated and the counters do not change.
- Read/write collision: when Decode reads the index being written in the same cycle, `predTakenD` uses the updated entry (write-first bypass).
- Target correctness is not checked; the Decode-computed target is authoritative.

## Timing
- `predTakenD`: combinational, same cycle as `PCD`.
- Table update: visible at the next clock edge; bypassed as described in Operation.
- Redirect latency: mispredict resolved in cycle N → `redirectF`/`flush*` high in cycle N+1 only.
- A stall asserted in the resolve cycle defers resolution; the branch must be held in Execute until `stallE`=0.
- Back-to-back mispredicts are impossible: the cycle after FLUSH is RUN and sees a fresh instruction.
- Reset values (asynchronous, immediate):
  - state RUN;
  - all entries 01;
  - `redirectF`, `flushD`, `flushE` = 0;
  - `redirectPCF` = 0;
  - both counters 0.
- Reset during FLUSH aborts the redirect.

## Configuration
- `BRANCH_CTRL_PERF_EN` defined:
  - `branchCount` increments on every resolve event.
  - `mispredCount` increments on every mispredicting resolve event.
  - Both counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- Not defined: counter flops are not built and both ports are tied to 0. Ports remain present.

## Structure
- Shared package `branch_pkg`:
  - `bht_ctr_t` (2-bit counter typedef);
  - constants `BHT_WEAK_NT`=2'b01 and `BHT_STRONG_T`=2'b11;
  - FSM enum `bctrl_state_t {RUN, FLUSH}`.
- One sub-module, `bht_table`: counter array with one read port, one read-modify-write update port, the bypass, and reset-to-01. The FSM, redirect register and counters stay in `branch_ctrl`.

## Test plan
- Reset, then `PCD`=0x100, `branchD`=1 → `predTakenD`=0. All outputs and counters are 0.
- Resolve `PCE`=0x100 taken twice with `predTakenE`=0:
  - first resolve → mispredict, redirect to `PCTargetE`=0x200 next cycle with a one-cycle flush;
  - afterwards `predTakenD`(0x100)=1.
- Correct prediction (`predTakenE`=1, taken) → no redirect, entry saturates at 11. With `BRANCH_CTRL_PERF_EN`: `branchCount`+1, `mispredCount` unchanged.
- Mispredict followed by a mispredicting branch in Execute during FLUSH → second branch ignored: no table update, no second redirect.
- `stallE`=1 with a mispredicting branch for 3 cycles, then 0 → redirect only in the cycle after stall release. `PCPlus4E`=0x104 for the not-taken case.
- Same-cycle update and read of index 5 (`PCE`=`PCD`=0x14, entry 01→10) → `predTakenD`=1. Assert `rst_n`=0 during FLUSH → `redirectF` drops immediately.
